// File: rtl/fpu_issue_sequencer_if.sv
// Decode/FPU-side handshake bundle for the FP issue sequencer.
// The sequencer uses the slave modport; the driving environment uses master.
interface fpu_issue_sequencer_if #(
  parameter int RD_W = 5
);
  logic            inst_valid;
  logic [6:0]      inst_opcode;
  logic [RD_W-1:0] inst_rd;
  logic            halt_req;
  logic            fpu_complete;
  logic            err_clr;
  logic            fpu_start;
  logic [6:0]      fpu_opcode;
  logic            stall_scalar;
  logic            fpu_active;
  logic            wb_valid;
  logic [RD_W-1:0] wb_rd;
  logic            halted;
  logic            timeout_err;
  logic [15:0]     issue_count;

  modport master (
    output inst_valid, inst_opcode, inst_rd, halt_req, fpu_complete, err_clr,
    input  fpu_start, fpu_opcode, stall_scalar, fpu_active, wb_valid, wb_rd,
           halted, timeout_err, issue_count
  );

  modport slave (
    input  inst_valid, inst_opcode, inst_rd, halt_req, fpu_complete, err_clr,
    output fpu_start, fpu_opcode, stall_scalar, fpu_active, wb_valid, wb_rd,
           halted, timeout_err, issue_count
  );
endinterface

// File: rtl/fpu_issue_sequencer.sv
// Single-issue FP sequencer between scalar decode and the FPU: launches one op,
// stalls the scalar pipe until completion or watchdog abort, parks on debug halt.
module fpu_issue_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int RD_W           = 5
) (
  input logic                 clk,
  input logic                 rst,
  fpu_issue_sequencer_if.slave bus
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_WB     = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  function automatic logic is_fp(input logic [6:0] op);
    case (op)
      7'h53, 7'h43, 7'h47, 7'h4B, 7'h4F: is_fp = 1'b1;
      default:                           is_fp = 1'b0;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [6:0]      opcode_q, opcode_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            fpu_start_q, fpu_start_d;
  logic            fpu_active_q, fpu_active_d;
  logic            wb_valid_q, wb_valid_d;
  logic            halted_q, halted_d;
  logic            expire;
  logic            fp_req;

  assign fp_req = bus.inst_valid & is_fp(bus.inst_opcode);

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    rd_d     = rd_q;
    wd_d     = wd_q;
    cnt_d    = cnt_q;
    expire   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Halt is checked first so debug can always park between instructions.
        if (bus.halt_req) begin
          state_d = S_HALTED;
        end else if (fp_req) begin
          opcode_d = bus.inst_opcode;
          rd_d     = bus.inst_rd;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        cnt_d   = cnt_q + 16'd1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Completion beats a same-cycle watchdog expiry.
        if (bus.fpu_complete) begin
          state_d = S_WB;
        end else if (wd_q == WD_LAST) begin
          expire  = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_WB: begin
        state_d = bus.halt_req ? S_HALTED : S_IDLE;
      end
      S_HALTED: begin
        if (!bus.halt_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    err_d = expire ? 1'b1 : (bus.err_clr ? 1'b0 : err_q);

    // Outputs are decoded from the next state so they line up with the state register.
    fpu_start_d  = (state_d == S_ISSUE);
    fpu_active_d = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_WB);
    wb_valid_d   = (state_d == S_WB);
    halted_d     = (state_d == S_HALTED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      opcode_q     <= '0;
      rd_q         <= '0;
      wd_q         <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      fpu_start_q  <= 1'b0;
      fpu_active_q <= 1'b0;
      wb_valid_q   <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      rd_q         <= rd_d;
      wd_q         <= wd_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      fpu_start_q  <= fpu_start_d;
      fpu_active_q <= fpu_active_d;
      wb_valid_q   <= wb_valid_d;
      halted_q     <= halted_d;
    end
  end

  // An FP instruction arriving in WB is held off and taken in the next IDLE cycle.
  assign bus.stall_scalar = (state_q == S_HALTED) | bus.halt_req |
                            (state_q == S_ISSUE) | (state_q == S_WAIT) |
                            (((state_q == S_IDLE) | (state_q == S_WB)) & fp_req);

  assign bus.fpu_start   = fpu_start_q;
  assign bus.fpu_opcode  = opcode_q;
  assign bus.fpu_active  = fpu_active_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_rd       = rd_q;
  assign bus.halted      = halted_q;
  assign bus.timeout_err = err_q;
  assign bus.issue_count = cnt_q;

endmodule

// File: tb/tb_fpu_issue_sequencer.sv
// Scenario bench for fpu_issue_sequencer; writebacks are checked against a
// queue of expected {opcode, rd} pushed when each FP instruction is accepted.
module tb_fpu_issue_sequencer;

  logic clk;
  logic rst;

  fpu_issue_sequencer_if #(.RD_W(5)) bus ();

  fpu_issue_sequencer #(
    .TIMEOUT_CYCLES(4),
    .RD_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [6:0] op;
    logic [4:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_err;
  int   wb_seen;
  int   exp_issues;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL sim_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  // Writeback scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (bus.wb_valid === 1'b1) begin
      wb_seen++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL wb_unexpected: wb_valid=1 rd=%0d op=%h, required no writeback", bus.wb_rd, bus.fpu_opcode);
      end else begin
        e = exp_q.pop_front();
        if (bus.wb_rd !== e.rd || bus.fpu_opcode !== e.op) begin
          n_err++;
          $display("FAIL wb_data: rd=%0d op=%h, required rd=%0d op=%h", bus.wb_rd, bus.fpu_opcode, e.rd, e.op);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_inst(input logic v, input logic [6:0] op, input logic [4:0] rd);
    bus.inst_valid  = v;
    bus.inst_opcode = op;
    bus.inst_rd     = rd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_inst(1'b0, 7'h00, 5'd0);
    bus.halt_req = 1'b0; bus.fpu_complete = 1'b0; bus.err_clr = 1'b0;
    repeat (2) step();
    n_cmp++;
    if ({bus.fpu_start, bus.fpu_opcode, bus.stall_scalar, bus.fpu_active, bus.wb_valid,
         bus.wb_rd, bus.halted, bus.timeout_err, bus.issue_count} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: start=%b op=%h stall=%b act=%b wb=%b rd=%0d halt=%b err=%b cnt=%0d, required all 0",
               bus.fpu_start, bus.fpu_opcode, bus.stall_scalar, bus.fpu_active, bus.wb_valid,
               bus.wb_rd, bus.halted, bus.timeout_err, bus.issue_count);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_fadd();
    step();                                    // T
    drive_inst(1'b1, 7'h43, 5'd7);
    exp_q.push_back('{op: 7'h43, rd: 5'd7}); exp_issues++;
    #1; n_cmp++;
    if (bus.stall_scalar !== 1'b1) begin n_err++; $display("FAIL fadd_stall_accept: %b, required 1", bus.stall_scalar); end
    step();                                    // T+1
    drive_inst(1'b0, 7'h00, 5'd0);
    n_cmp++;
    if (bus.fpu_start !== 1'b1 || bus.fpu_active !== 1'b1) begin
      n_err++; $display("FAIL fadd_start: start=%b act=%b, required 1 1", bus.fpu_start, bus.fpu_active);
    end
    n_cmp++;
    if (bus.fpu_opcode !== 7'h43) begin n_err++; $display("FAIL fadd_opcode: %h, required 43", bus.fpu_opcode); end
    step();                                    // T+2
    n_cmp++;
    if (bus.fpu_start !== 1'b0 || bus.stall_scalar !== 1'b1) begin
      n_err++; $display("FAIL fadd_wait: start=%b stall=%b, required 0 1", bus.fpu_start, bus.stall_scalar);
    end
    repeat (3) step();                         // T+5: complete coincides with watchdog expiry
    bus.fpu_complete = 1'b1;
    step();                                    // T+6
    bus.fpu_complete = 1'b0;
    #1; n_cmp++;
    if (bus.wb_valid !== 1'b1 || bus.stall_scalar !== 1'b0 || bus.timeout_err !== 1'b0) begin
      n_err++; $display("FAIL fadd_wb: wb=%b stall=%b err=%b, required 1 0 0", bus.wb_valid, bus.stall_scalar, bus.timeout_err);
    end
    step();                                    // T+7
    n_cmp++;
    if (bus.wb_valid !== 1'b0 || bus.fpu_active !== 1'b0 || bus.issue_count !== 16'(exp_issues)) begin
      n_err++; $display("FAIL fadd_after: wb=%b act=%b cnt=%0d, required 0 0 %0d", bus.wb_valid, bus.fpu_active, bus.issue_count, exp_issues);
    end
  endtask

  task automatic test_non_fp();
    step();
    drive_inst(1'b1, 7'h33, 5'd5);
    #1; n_cmp++;
    if (bus.stall_scalar !== 1'b0) begin n_err++; $display("FAIL nonfp_stall: %b, required 0", bus.stall_scalar); end
    repeat (2) step();
    n_cmp++;
    if (bus.fpu_start !== 1'b0 || bus.fpu_active !== 1'b0) begin
      n_err++; $display("FAIL nonfp_issue: start=%b act=%b, required 0 0", bus.fpu_start, bus.fpu_active);
    end
    drive_inst(1'b0, 7'h00, 5'd0);
  endtask

  task automatic test_timeout();
    int wb_before;
    wb_before = wb_seen;
    step();                                    // T
    drive_inst(1'b1, 7'h53, 5'd3);
    exp_issues++;
    step();                                    // T+1
    drive_inst(1'b0, 7'h00, 5'd0);
    repeat (4) step();                         // T+5: last WAIT cycle
    n_cmp++;
    if (bus.timeout_err !== 1'b0) begin n_err++; $display("FAIL timeout_early: err=%b, required 0", bus.timeout_err); end
    step();                                    // T+6
    n_cmp++;
    if (bus.timeout_err !== 1'b1 || bus.fpu_active !== 1'b0 || bus.stall_scalar !== 1'b0) begin
      n_err++; $display("FAIL timeout_set: err=%b act=%b stall=%b, required 1 0 0", bus.timeout_err, bus.fpu_active, bus.stall_scalar);
    end
    bus.err_clr = 1'b1;
    step();                                    // T+7
    bus.err_clr = 1'b0;
    n_cmp++;
    if (bus.timeout_err !== 1'b0 || bus.issue_count !== 16'(exp_issues) || wb_seen != wb_before) begin
      n_err++; $display("FAIL timeout_clear: err=%b cnt=%0d wbs=%0d, required 0 %0d %0d",
                        bus.timeout_err, bus.issue_count, wb_seen - wb_before, exp_issues, 0);
    end
  endtask

  task automatic test_halt_mid_wait();
    step();                                    // T
    drive_inst(1'b1, 7'h4B, 5'd12);
    exp_q.push_back('{op: 7'h4B, rd: 5'd12}); exp_issues++;
    step();                                    // T+1
    drive_inst(1'b0, 7'h00, 5'd0);
    step();                                    // T+2 WAIT
    bus.halt_req = 1'b1;
    step();                                    // T+3
    bus.fpu_complete = 1'b1;
    n_cmp++;
    if (bus.fpu_active !== 1'b1 || bus.halted !== 1'b0) begin
      n_err++; $display("FAIL halt_no_abort: act=%b halted=%b, required 1 0", bus.fpu_active, bus.halted);
    end
    step();                                    // T+4 WB
    bus.fpu_complete = 1'b0;
    n_cmp++;
    if (bus.wb_valid !== 1'b1 || bus.halted !== 1'b0) begin
      n_err++; $display("FAIL halt_wb: wb=%b halted=%b, required 1 0", bus.wb_valid, bus.halted);
    end
    drive_inst(1'b1, 7'h53, 5'd9);
    step();                                    // T+5 HALTED
    n_cmp++;
    if (bus.halted !== 1'b1 || bus.fpu_active !== 1'b0 || bus.stall_scalar !== 1'b1) begin
      n_err++; $display("FAIL halt_parked: halted=%b act=%b stall=%b, required 1 0 1", bus.halted, bus.fpu_active, bus.stall_scalar);
    end
    step();                                    // T+6 still HALTED
    bus.halt_req = 1'b0;
    #1; n_cmp++;
    if (bus.halted !== 1'b1 || bus.stall_scalar !== 1'b1) begin
      n_err++; $display("FAIL halt_release_stall: halted=%b stall=%b, required 1 1", bus.halted, bus.stall_scalar);
    end
    step();                                    // T+7 IDLE, accepts 0x53
    exp_q.push_back('{op: 7'h53, rd: 5'd9}); exp_issues++;
    n_cmp++;
    if (bus.halted !== 1'b0 || bus.fpu_start !== 1'b0) begin
      n_err++; $display("FAIL halt_idle: halted=%b start=%b, required 0 0", bus.halted, bus.fpu_start);
    end
    step();                                    // T+8 ISSUE
    drive_inst(1'b0, 7'h00, 5'd0);
    n_cmp++;
    if (bus.fpu_start !== 1'b1 || bus.fpu_opcode !== 7'h53) begin
      n_err++; $display("FAIL halt_queued_issue: start=%b op=%h, required 1 53", bus.fpu_start, bus.fpu_opcode);
    end
    step();                                    // T+9 WAIT, minimum latency complete
    bus.fpu_complete = 1'b1;
    step();                                    // T+10 WB
    bus.fpu_complete = 1'b0;
    n_cmp++;
    if (bus.wb_valid !== 1'b1) begin n_err++; $display("FAIL halt_queued_wb: wb=%b, required 1", bus.wb_valid); end
    step();
  endtask

  task automatic test_back_to_back();
    step();                                    // T
    drive_inst(1'b1, 7'h47, 5'd4);
    exp_q.push_back('{op: 7'h47, rd: 5'd4}); exp_issues++;
    step();                                    // T+1
    drive_inst(1'b0, 7'h00, 5'd0);
    step();                                    // T+2
    step();                                    // T+3
    bus.fpu_complete = 1'b1;
    step();                                    // T+4 WB
    bus.fpu_complete = 1'b0;
    drive_inst(1'b1, 7'h4F, 5'd21);
    #1; n_cmp++;
    if (bus.wb_valid !== 1'b1 || bus.stall_scalar !== 1'b1) begin
      n_err++; $display("FAIL b2b_wb_stall: wb=%b stall=%b, required 1 1", bus.wb_valid, bus.stall_scalar);
    end
    step();                                    // T+5 IDLE, accepts 0x4F
    exp_q.push_back('{op: 7'h4F, rd: 5'd21}); exp_issues++;
    n_cmp++;
    if (bus.fpu_start !== 1'b0 || bus.wb_valid !== 1'b0 || bus.stall_scalar !== 1'b1) begin
      n_err++; $display("FAIL b2b_accept: start=%b wb=%b stall=%b, required 0 0 1", bus.fpu_start, bus.wb_valid, bus.stall_scalar);
    end
    step();                                    // T+6 ISSUE
    drive_inst(1'b0, 7'h00, 5'd0);
    n_cmp++;
    if (bus.fpu_start !== 1'b1) begin n_err++; $display("FAIL b2b_start: %b, required 1", bus.fpu_start); end
    step();                                    // T+7
    bus.fpu_complete = 1'b1;
    step();                                    // T+8 WB
    bus.fpu_complete = 1'b0;
    step();
    n_cmp++;
    if (bus.issue_count !== 16'(exp_issues) || exp_q.size() != 0) begin
      n_err++; $display("FAIL b2b_count: cnt=%0d pending=%0d, required %0d 0", bus.issue_count, exp_q.size(), exp_issues);
    end
  endtask

  task automatic test_reset_mid_wait();
    step();                                    // T
    drive_inst(1'b1, 7'h43, 5'd1);
    step();                                    // T+1
    drive_inst(1'b0, 7'h00, 5'd0);
    step();                                    // T+2 WAIT
    rst = 1'b1;
    exp_issues = 0;
    #1; n_cmp++;
    if ({bus.fpu_start, bus.fpu_opcode, bus.stall_scalar, bus.fpu_active, bus.wb_valid,
         bus.wb_rd, bus.halted, bus.timeout_err, bus.issue_count} !== '0) begin
      n_err++;
      $display("FAIL rst_async: start=%b op=%h stall=%b act=%b wb=%b rd=%0d halt=%b err=%b cnt=%0d, required all 0",
               bus.fpu_start, bus.fpu_opcode, bus.stall_scalar, bus.fpu_active, bus.wb_valid,
               bus.wb_rd, bus.halted, bus.timeout_err, bus.issue_count);
    end
    step();
    rst = 1'b0;
    step();
    bus.fpu_complete = 1'b1;
    step();
    bus.fpu_complete = 1'b0;
    n_cmp++;
    if (bus.wb_valid !== 1'b0 || bus.fpu_active !== 1'b0 || bus.issue_count !== 16'd0) begin
      n_err++; $display("FAIL rst_spurious: wb=%b act=%b cnt=%0d, required 0 0 0", bus.wb_valid, bus.fpu_active, bus.issue_count);
    end
    step();
    n_cmp++;
    if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL rst_spurious_late: wb=%b, required 0", bus.wb_valid); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; wb_seen = 0; exp_issues = 0;
    test_reset();
    test_fadd();
    test_non_fp();
    test_timeout();
    test_halt_mid_wait();
    test_back_to_back();
    test_reset_mid_wait();
    repeat (2) step();
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL pending_wb: %0d outstanding, required 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
